// File: rtl/key_entry_if.sv
// Keypad-side bundle for key_entry_buf.
// master: the keypad scanner and the consumer that drive the key and acknowledge inputs.
// slave:  the entry buffer that produces the buffered digits and status outputs.
interface key_entry_if #(
  parameter int MAX_DIGITS  = 16,
  parameter int SHOW_DIGITS = 4
);
  localparam int NW = $clog2(MAX_DIGITS + 1);
  localparam int OW = $clog2(SHOW_DIGITS + 1);

  logic                     IN_key;
  logic [3:0]               IN_value;
  logic                     IN_shank_hand;
  logic [4*MAX_DIGITS-1:0]  OUT_value;
  logic [NW-1:0]            OUT_number;
  logic                     OUT_finish;
  logic                     OUT_full;
  logic                     OUT_error;
  logic [OW-1:0]            OUT_off_number;
  logic [4*SHOW_DIGITS-1:0] OUT_show_value;

  modport master (
    output IN_key, IN_value, IN_shank_hand,
    input  OUT_value, OUT_number, OUT_finish, OUT_full, OUT_error,
           OUT_off_number, OUT_show_value
  );

  modport slave (
    input  IN_key, IN_value, IN_shank_hand,
    output OUT_value, OUT_number, OUT_finish, OUT_full, OUT_error,
           OUT_off_number, OUT_show_value
  );
endinterface

// File: rtl/key_entry_buf.sv
// Keypad entry buffer: collects BCD digits from a keypad scanner, supports
// backspace, clear-all and enter, and holds a finished entry frozen until the
// consumer acknowledges it. One action per rising edge of the key-valid level.
module key_entry_buf #(
  parameter int MAX_DIGITS   = 16,
  parameter int SHOW_DIGITS  = 4,
  parameter int CLEAR_ON_ACK = 0
) (
  input  logic        IN_clk,
  input  logic        IN_reset,
  key_entry_if.slave  bus
);
  localparam int NW = $clog2(MAX_DIGITS + 1);
  localparam int OW = $clog2(SHOW_DIGITS + 1);
  localparam int VW = 4 * MAX_DIGITS;
  localparam logic [NW-1:0] MAX_N  = NW'(MAX_DIGITS);
  localparam logic [NW-1:0] SHOW_N = NW'(SHOW_DIGITS);

  logic [VW-1:0] value_q, value_d;
  logic [NW-1:0] number_q, number_d;
  logic          finish_q, finish_d;
  logic          error_q, error_d;
  logic          key_prev_q, key_prev_d;
  logic          key_edge_s;
  logic [VW-1:0] digit_ext_s;
  logic [OW-1:0] off_number_s;

  // Next-state decode: one action per key rising edge, frozen while an entry is pending.
  always_comb begin
    key_edge_s     = bus.IN_key & ~key_prev_q;
    digit_ext_s    = '0;
    digit_ext_s[3:0] = bus.IN_value;
    value_d        = value_q;
    number_d       = number_q;
    finish_d       = finish_q;
    error_d        = 1'b0;
    key_prev_d     = bus.IN_key;
    if (finish_q) begin
      // Acknowledge is judged on the pre-edge finish flag, so a key arriving
      // in the same cycle is still rejected.
      if (bus.IN_shank_hand) begin
        finish_d = 1'b0;
        if (CLEAR_ON_ACK != 0) begin
          value_d  = '0;
          number_d = '0;
        end else begin
          value_d  = value_q;
        end
      end else begin
        finish_d = 1'b1;
      end
      if (key_edge_s) begin
        error_d = 1'b1;
      end else begin
        error_d = 1'b0;
      end
    end else if (key_edge_s) begin
      case (bus.IN_value)
        4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
        4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
          if (number_q < MAX_N) begin
            value_d  = (value_q << 4) | digit_ext_s;
            number_d = number_q + NW'(1);
          end else begin
            error_d = 1'b1;
          end
        end
        4'hD: begin
          value_d  = '0;
          number_d = '0;
        end
        4'hE: begin
          if (number_q != '0) begin
            value_d  = value_q >> 4;
            number_d = number_q - NW'(1);
          end else begin
            error_d = 1'b1;
          end
        end
        4'hF: begin
          if (number_q != '0) begin
            finish_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
        default: begin
          error_d = 1'b0;
        end
      endcase
    end else begin
      error_d = 1'b0;
    end
  end

  // State registers; edge detector resets high so a key held through reset is not taken.
  always_ff @(posedge IN_clk or negedge IN_reset) begin
    if (!IN_reset) begin
      value_q    <= '0;
      number_q   <= '0;
      finish_q   <= 1'b0;
      error_q    <= 1'b0;
      key_prev_q <= 1'b1;
    end else begin
      value_q    <= value_d;
      number_q   <= number_d;
      finish_q   <= finish_d;
      error_q    <= error_d;
      key_prev_q <= key_prev_d;
    end
  end

  // Count of display positions left blank when fewer digits than the display width are held.
  always_comb begin
    if (number_q < SHOW_N) begin
      off_number_s = OW'(SHOW_N - number_q);
    end else begin
      off_number_s = '0;
    end
  end

  assign bus.OUT_value      = value_q;
  assign bus.OUT_number     = number_q;
  assign bus.OUT_finish     = finish_q;
  assign bus.OUT_error      = error_q;
  assign bus.OUT_full       = (number_q == MAX_N);
  assign bus.OUT_off_number = off_number_s;
  assign bus.OUT_show_value = value_q[4*SHOW_DIGITS-1:0];
endmodule

// File: tb/tb_key_entry_buf.sv
// Directed bench for key_entry_buf: a default instance (retain on ack) and a
// small instance (5 digits, 2 shown, clear on ack) share clock and reset.
module tb_key_entry_buf;
  logic clk;
  logic rst_n;
  int   chk_cnt;
  int   fail_cnt;

  key_entry_if #(.MAX_DIGITS(16), .SHOW_DIGITS(4)) ifa ();
  key_entry_if #(.MAX_DIGITS(5),  .SHOW_DIGITS(2)) ifb ();

  key_entry_buf #(.MAX_DIGITS(16), .SHOW_DIGITS(4), .CLEAR_ON_ACK(0)) dut_a (
    .IN_clk   (clk),
    .IN_reset (rst_n),
    .bus      (ifa.slave)
  );

  key_entry_buf #(.MAX_DIGITS(5), .SHOW_DIGITS(2), .CLEAR_ON_ACK(1)) dut_b (
    .IN_clk   (clk),
    .IN_reset (rst_n),
    .bus      (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt = chk_cnt + 1;
    if (got !== exp) begin
      fail_cnt = fail_cnt + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One press: key high for one cycle; returns at the negedge after the update edge.
  task automatic press(input int sel, input logic [3:0] v);
    @(negedge clk);
    if (sel == 0) begin ifa.IN_key = 1'b1; ifa.IN_value = v; end
    else begin ifb.IN_key = 1'b1; ifb.IN_value = v; end
    @(negedge clk);
    if (sel == 0) ifa.IN_key = 1'b0;
    else ifb.IN_key = 1'b0;
  endtask

  task automatic ack(input int sel);
    @(negedge clk);
    if (sel == 0) ifa.IN_shank_hand = 1'b1;
    else ifb.IN_shank_hand = 1'b1;
    @(negedge clk);
    if (sel == 0) ifa.IN_shank_hand = 1'b0;
    else ifb.IN_shank_hand = 1'b0;
  endtask

  initial begin
    chk_cnt = 0;
    fail_cnt = 0;
    rst_n = 1'b0;
    ifa.IN_key = 1'b0; ifa.IN_value = 4'h0; ifa.IN_shank_hand = 1'b0;
    ifb.IN_key = 1'b0; ifb.IN_value = 4'h0; ifb.IN_shank_hand = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_value",  64'(ifa.OUT_value), 64'h0);
    check_eq("rst_number", 64'(ifa.OUT_number), 64'd0);
    check_eq("rst_finish", 64'(ifa.OUT_finish), 64'd0);
    check_eq("rst_error",  64'(ifa.OUT_error), 64'd0);
    check_eq("rst_off",    64'(ifa.OUT_off_number), 64'd4);
    check_eq("rst_full",   64'(ifa.OUT_full), 64'd0);
    rst_n = 1'b1;

    // 1,2,3
    press(0, 4'h1); press(0, 4'h2); press(0, 4'h3);
    check_eq("d123_value", 64'(ifa.OUT_value), 64'h123);
    check_eq("d123_number", 64'(ifa.OUT_number), 64'd3);
    check_eq("d123_off", 64'(ifa.OUT_off_number), 64'd1);
    check_eq("d123_show", 64'(ifa.OUT_show_value), 64'h0123);
    check_eq("d123_error", 64'(ifa.OUT_error), 64'd0);
    press(0, 4'hD);
    check_eq("clr_value", 64'(ifa.OUT_value), 64'h0);
    check_eq("clr_number", 64'(ifa.OUT_number), 64'd0);
    check_eq("clr_error", 64'(ifa.OUT_error), 64'd0);

    // backspace on empty, then 4,5,E
    press(0, 4'hE);
    check_eq("bs_empty_err", 64'(ifa.OUT_error), 64'd1);
    check_eq("bs_empty_num", 64'(ifa.OUT_number), 64'd0);
    @(negedge clk);
    check_eq("bs_err_pulse", 64'(ifa.OUT_error), 64'd0);
    press(0, 4'h4); press(0, 4'h5); press(0, 4'hE);
    check_eq("bs_value", 64'(ifa.OUT_value), 64'h4);
    check_eq("bs_number", 64'(ifa.OUT_number), 64'd1);

    // fill with 7s, then overflow
    press(0, 4'hD);
    for (int i = 0; i < 16; i++) press(0, 4'h7);
    check_eq("full_flag", 64'(ifa.OUT_full), 64'd1);
    check_eq("full_number", 64'(ifa.OUT_number), 64'd16);
    check_eq("full_value", 64'(ifa.OUT_value), 64'h7777_7777_7777_7777);
    check_eq("full_off", 64'(ifa.OUT_off_number), 64'd0);
    press(0, 4'h7);
    check_eq("ovf_error", 64'(ifa.OUT_error), 64'd1);
    check_eq("ovf_value", 64'(ifa.OUT_value), 64'h7777_7777_7777_7777);
    check_eq("ovf_number", 64'(ifa.OUT_number), 64'd16);
    @(negedge clk);
    check_eq("ovf_pulse", 64'(ifa.OUT_error), 64'd0);

    // ignored code and enter on empty
    press(0, 4'hD);
    press(0, 4'hB);
    check_eq("ign_error", 64'(ifa.OUT_error), 64'd0);
    check_eq("ign_number", 64'(ifa.OUT_number), 64'd0);
    press(0, 4'hF);
    check_eq("ent_empty_err", 64'(ifa.OUT_error), 64'd1);
    check_eq("ent_empty_fin", 64'(ifa.OUT_finish), 64'd0);

    // 9, F, 3 rejected, ack retains buffer
    press(0, 4'h9); press(0, 4'hF);
    check_eq("ent_finish", 64'(ifa.OUT_finish), 64'd1);
    press(0, 4'h3);
    check_eq("frz_error", 64'(ifa.OUT_error), 64'd1);
    check_eq("frz_value", 64'(ifa.OUT_value), 64'h9);
    check_eq("frz_number", 64'(ifa.OUT_number), 64'd1);
    ack(0);
    check_eq("ack_finish", 64'(ifa.OUT_finish), 64'd0);
    check_eq("ack_value", 64'(ifa.OUT_value), 64'h9);
    check_eq("ack_number", 64'(ifa.OUT_number), 64'd1);

    // key edge in the acknowledging cycle
    press(0, 4'hF);
    check_eq("ent2_finish", 64'(ifa.OUT_finish), 64'd1);
    @(negedge clk);
    ifa.IN_shank_hand = 1'b1; ifa.IN_key = 1'b1; ifa.IN_value = 4'h2;
    @(negedge clk);
    ifa.IN_shank_hand = 1'b0; ifa.IN_key = 1'b0;
    check_eq("coin_finish", 64'(ifa.OUT_finish), 64'd0);
    check_eq("coin_error", 64'(ifa.OUT_error), 64'd1);
    check_eq("coin_value", 64'(ifa.OUT_value), 64'h9);
    check_eq("coin_number", 64'(ifa.OUT_number), 64'd1);
    @(negedge clk);
    check_eq("coin_pulse", 64'(ifa.OUT_error), 64'd0);

    // ack while idle has no effect
    ack(0);
    check_eq("idle_ack_fin", 64'(ifa.OUT_finish), 64'd0);
    check_eq("idle_ack_val", 64'(ifa.OUT_value), 64'h9);

    // held key: one digit; reset mid-hold, key held through release
    press(0, 4'hD);
    @(negedge clk);
    ifa.IN_key = 1'b1; ifa.IN_value = 4'h5;
    repeat (10) @(negedge clk);
    check_eq("hold_number", 64'(ifa.OUT_number), 64'd1);
    check_eq("hold_value", 64'(ifa.OUT_value), 64'h5);
    rst_n = 1'b0;
    #1;
    check_eq("hold_rst_num", 64'(ifa.OUT_number), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("hold_rel_num", 64'(ifa.OUT_number), 64'd0);
    check_eq("hold_rel_err", 64'(ifa.OUT_error), 64'd0);
    ifa.IN_key = 1'b0;
    press(0, 4'h6);
    check_eq("post_rst_val", 64'(ifa.OUT_value), 64'h6);
    check_eq("post_rst_num", 64'(ifa.OUT_number), 64'd1);

    // reset while finish is pending
    press(0, 4'h8); press(0, 4'hF);
    check_eq("pend_finish", 64'(ifa.OUT_finish), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("pend_rst_fin", 64'(ifa.OUT_finish), 64'd0);
    check_eq("pend_rst_num", 64'(ifa.OUT_number), 64'd0);
    press(0, 4'h2);
    check_eq("pend_new_val", 64'(ifa.OUT_value), 64'h2);
    check_eq("pend_new_num", 64'(ifa.OUT_number), 64'd1);

    // small instance: 5 digits, 2 shown, clear on ack
    check_eq("b_rst_off", 64'(ifb.OUT_off_number), 64'd2);
    for (int i = 1; i <= 5; i++) press(1, 4'(i));
    check_eq("b_number", 64'(ifb.OUT_number), 64'd5);
    check_eq("b_show", 64'(ifb.OUT_show_value), 64'h45);
    check_eq("b_value", 64'(ifb.OUT_value), 64'h12345);
    check_eq("b_full", 64'(ifb.OUT_full), 64'd1);
    check_eq("b_off_full", 64'(ifb.OUT_off_number), 64'd0);
    press(1, 4'h6);
    check_eq("b_ovf_err", 64'(ifb.OUT_error), 64'd1);
    check_eq("b_ovf_val", 64'(ifb.OUT_value), 64'h12345);
    press(1, 4'hD);
    check_eq("b_clr_val", 64'(ifb.OUT_value), 64'h0);
    check_eq("b_clr_num", 64'(ifb.OUT_number), 64'd0);
    check_eq("b_clr_off", 64'(ifb.OUT_off_number), 64'd2);
    check_eq("b_clr_full", 64'(ifb.OUT_full), 64'd0);
    press(1, 4'h3); press(1, 4'h4); press(1, 4'hE);
    check_eq("b_bs_val", 64'(ifb.OUT_value), 64'h3);
    check_eq("b_bs_off", 64'(ifb.OUT_off_number), 64'd1);
    press(1, 4'h9); press(1, 4'hF);
    check_eq("b_ent_fin", 64'(ifb.OUT_finish), 64'd1);
    ack(1);
    check_eq("b_ack_fin", 64'(ifb.OUT_finish), 64'd0);
    check_eq("b_ack_val", 64'(ifb.OUT_value), 64'h0);
    check_eq("b_ack_num", 64'(ifb.OUT_number), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
    $finish;
  end
endmodule
